muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit implementing the RV32M function set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for a generic WORD width.
- Sits beside the single-cycle ALU in the execute stage.
- Accepts one operation per valid/ready handshake, computes it over roughly WORD cycles with a shift-add / restoring-division datapath, and holds the result until the consumer accepts it.
- Supports abort (Flush) for pipeline flushes.

---
 rtl/muldiv_unit.sv | 204 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// one result bit per cycle, result held until the consumer accepts it.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | WORD iterations of shift-add or restoring division
// FIX   | sign correction and output selection
// DONE  | Result valid, waiting for Out_ready
module muldiv_unit #(
  parameter int WORD = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            Flush,
  input  logic            In_valid,
  output logic            In_ready,
  input  logic [2:0]      Function_select,
  input  logic [WORD-1:0] A_in,
  input  logic [WORD-1:0] B_in,
  output logic            Out_valid,
  input  logic            Out_ready,
  output logic [WORD-1:0] Result,
  output logic            Busy
);

  localparam int CW = $clog2(WORD + 1);
  localparam logic [WORD-1:0] MIN_NEG = {1'b1, {(WORD-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          func_q, func_d;
  logic                neg_q, neg_d;
  logic [WORD-1:0]     a_q, a_d;
  logic [WORD-1:0]     b_q, b_d;
  logic [2*WORD-1:0]   prod_q, prod_d;
  logic [WORD-1:0]     rem_q, rem_d;
  logic [WORD-1:0]     quo_q, quo_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WORD-1:0]     result_q, result_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic                sign_a_en, sign_b_en;
  logic                sa, sb;
  logic [WORD-1:0]     abs_a, abs_b;
  logic                div_zero, div_ovf;
  logic [WORD-1:0]     special_val;
  logic [WORD:0]       add_sum;
  logic [2*WORD-1:0]   prod_step;
  logic [WORD:0]       div_shift, div_diff;
  logic [2*WORD-1:0]   prod_fix;
  logic [WORD-1:0]     quo_fix, rem_fix;
  logic [WORD-1:0]     fix_sel;

  always_comb begin
    sign_a_en = 1'b0;
    sign_b_en = 1'b0;
    case (Function_select)
      3'd1, 3'd4, 3'd6: begin sign_a_en = 1'b1; sign_b_en = 1'b1; end
      3'd2:             sign_a_en = 1'b1;
      default:          ;
    endcase
    sa    = sign_a_en & A_in[WORD-1];
    sb    = sign_b_en & B_in[WORD-1];
    abs_a = sa ? -A_in : A_in;
    abs_b = sb ? -B_in : B_in;

    div_zero = Function_select[2] && (B_in == '0);
    div_ovf  = ((Function_select == 3'd4) || (Function_select == 3'd6)) &&
               (A_in == MIN_NEG) && (B_in == '1);
    // Function_select[1] distinguishes REM* from DIV* within the divide group
    if (Function_select[1])
      special_val = div_zero ? A_in : '0;
    else
      special_val = div_zero ? '1 : A_in;
  end

  always_comb begin
    add_sum   = {1'b0, prod_q[2*WORD-1:WORD]} + {1'b0, a_q};
    prod_step = prod_q[0] ? {add_sum, prod_q[WORD-1:1]}
                          : {1'b0, prod_q[2*WORD-1:1]};

    div_shift = {rem_q, quo_q[WORD-1]};
    div_diff  = div_shift - {1'b0, b_q};

    prod_fix = neg_q ? -prod_q : prod_q;
    quo_fix  = neg_q ? -quo_q : quo_q;
    rem_fix  = neg_q ? -rem_q : rem_q;
    case (func_q)
      3'd0:             fix_sel = prod_fix[WORD-1:0];
      3'd1, 3'd2, 3'd3: fix_sel = prod_fix[2*WORD-1:WORD];
      3'd4, 3'd5:       fix_sel = quo_fix;
      default:          fix_sel = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    if (Flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (In_valid) begin
            func_d = Function_select;
            neg_d  = (Function_select == 3'd6) ? sa : (sa ^ sb);
            a_d    = abs_a;
            b_d    = abs_b;
            prod_d = {{WORD{1'b0}}, abs_b};
            quo_d  = abs_a;
            rem_d  = '0;
            cnt_d  = CW'(WORD);
            if (div_zero || div_ovf) begin
              result_d = special_val;
              state_d  = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          cnt_d = cnt_q - CW'(1);
          if (func_q[2]) begin
            // restore by keeping the shifted value when the trial subtract borrows
            if (!div_diff[WORD]) begin
              rem_d = div_diff[WORD-1:0];
              quo_d = {quo_q[WORD-2:0], 1'b1};
            end else begin
              rem_d = div_shift[WORD-1:0];
              quo_d = {quo_q[WORD-2:0], 1'b0};
            end
          end else begin
            prod_d = prod_step;
          end
          if (cnt_q == CW'(1))
            state_d = S_FIX;
        end
        S_FIX: begin
          result_d = fix_sel;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (Out_ready)
            state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      func_q      <= '0;
      neg_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      prod_q      <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      func_q      <= func_d;
      neg_q       <= neg_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign In_ready  = in_ready_q;
  assign Out_valid = out_valid_q;
  assign Result    = result_q;
  assign Busy      = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, latency, backpressure,
// flush and reset, plus randomized operations against an arithmetic reference.
module tb_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          Flush = 1'b0;
  logic          In_valid = 1'b0;
  logic          In_ready;
  logic [2:0]    Function_select = 3'd0;
  logic [W-1:0]  A_in = '0;
  logic [W-1:0]  B_in = '0;
  logic          Out_valid;
  logic          Out_ready = 1'b0;
  logic [W-1:0]  Result;
  logic          Busy;

  int total = 0;
  int bad = 0;

  muldiv_unit #(.WORD(W)) dut (
    .clk(clk), .rst_n(rst_n), .Flush(Flush), .In_valid(In_valid), .In_ready(In_ready),
    .Function_select(Function_select), .A_in(A_in), .B_in(B_in),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Result(Result), .Busy(Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W + 2;
  endfunction

  // Called at a negedge; returns at a negedge with the unit idle again.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp;
    int          n;
    exp = ref_op(f, a, b);
    n = 0;
    while (!In_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_inrdy"}, In_ready, 1);
    Function_select = f;
    A_in = a;
    B_in = b;
    In_valid = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      In_valid = 1'b0;
      A_in = $urandom;
      B_in = $urandom;
      Function_select = 3'($urandom_range(0, 7));
    end while (!Out_valid && n < 200);
    check({tag, "_lat"}, n, exp_latency(f, a, b));
    check({tag, "_res"}, Result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      A_in = $urandom;
      B_in = $urandom;
      check({tag, "_hold_res"}, Result, exp);
      check({tag, "_hold_vld"}, Out_valid, 1);
      check({tag, "_hold_rdy"}, In_ready, 0);
      check({tag, "_hold_busy"}, Busy, 1);
    end
    Out_ready = 1'b1;
    @(negedge clk);
    Out_ready = 1'b0;
    check({tag, "_post_vld"}, Out_valid, 0);
    check({tag, "_post_rdy"}, In_ready, 1);
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int          n;

    repeat (2) @(negedge clk);
    check("rst_inrdy", In_ready, 1);
    check("rst_ovld", Out_valid, 0);
    check("rst_busy", Busy, 0);
    check("rst_result", Result, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // reset in the middle of a calculation
    Function_select = 3'd0; A_in = 32'd5; B_in = 32'd6; In_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    In_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("midcalc_busy", Busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_ovld", Out_valid, 0);
    check("arst_inrdy", In_ready, 1);
    check("arst_busy", Busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("mul3x4", 3'd0, 32'd3, 32'd4, 0);

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu", 3'd5, 32'd100, 32'd7, 0);
    run_op("remu", 3'd7, 32'd100, 32'd7, 0);
    run_op("divu0", 3'd5, 32'd100, 32'd0, 0);
    run_op("remu0", 3'd7, 32'd100, 32'd0, 0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("bp", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 20);

    // flush during CALC with a simultaneous request
    Function_select = 3'd5; A_in = 32'd1000; B_in = 32'd3; In_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    In_valid = 1'b0;
    repeat (4) @(negedge clk);
    Flush = 1'b1; In_valid = 1'b1; Function_select = 3'd0; A_in = 32'd9; B_in = 32'd9;
    @(negedge clk);
    Flush = 1'b0; In_valid = 1'b0;
    check("flcalc_ovld", Out_valid, 0);
    check("flcalc_inrdy", In_ready, 1);
    check("flcalc_busy", Busy, 0);
    run_op("after_flcalc", 3'd4, 32'hFFFF_FF00, 32'd16, 0);

    // flush while holding a result in DONE
    Function_select = 3'd3; A_in = 32'hDEAD_BEEF; B_in = 32'h0000_1000; In_valid = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      In_valid = 1'b0;
    end while (!Out_valid && n < 200);
    check("fldone_reach", Out_valid, 1);
    Flush = 1'b1; In_valid = 1'b1; Function_select = 3'd0; A_in = 32'd2; B_in = 32'd2;
    @(negedge clk);
    Flush = 1'b0; In_valid = 1'b0;
    check("fldone_ovld", Out_valid, 0);
    check("fldone_inrdy", In_ready, 1);
    check("fldone_busy", Busy, 0);
    run_op("after_fldone", 3'd6, 32'd12345, 32'hFFFF_FFF9, 0);

    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(0, 50)) - 32'd25; b = 32'($urandom_range(0, 12)) - 32'd6; end
        default: ;
      endcase
      run_op("rand", f, a, b, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
